serv_bus_sched: RTL and testbench
=================================

SERV_BUS_SCHED -- requirements
Module: serv_bus_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..255: cycles without i_wb_ack before a timeout completes the transfer.
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_ibus_adr  input  32, i_ibus_cyc  input  1, o_ibus_rdt  output  32, o_ibus_ack  output  1: the instruction-fetch requester.
REQ-005 SHALL have ports i_dbus_adr  input  32, i_dbus_dat  input  32, i_dbus_sel  input  4, i_dbus_we  input  1, i_dbus_cyc  input  1, o_dbus_rdt  output  32, o_dbus_ack  output  1: the data requester.
REQ-006 SHALL have ports o_wb_adr  output  32, o_wb_dat  output  32, o_wb_sel  output  4, o_wb_we  output  1, o_wb_cyc  output  1, i_wb_rdt  input  32, i_wb_ack  input  1: the shared memory port.
REQ-007 SHALL have port o_timeout  output  1: one-cycle pulse when a transfer is force-completed.

Function
REQ-008 SHALL implement a registered FSM with states IDLE, IBUS, DBUS, plus a 1-bit last_grant register (0 = ibus, 1 = dbus).
REQ-009 IDLE: only i_ibus_cyc -> IBUS; only i_dbus_cyc -> DBUS; both -> the requester not named by last_grant; neither -> stay in IDLE.
REQ-010 On entering IBUS or DBUS, SHALL set last_grant to the granted requester.
REQ-011 o_wb_cyc SHALL be (state==IBUS & i_ibus_cyc) | (state==DBUS & i_dbus_cyc), and SHALL be 0 in IDLE.
REQ-012 In IBUS: o_wb_adr = i_ibus_adr, o_wb_we = 0, o_wb_sel = 4'b1111, o_wb_dat = 0.
REQ-013 In DBUS: o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we SHALL pass i_dbus_* through combinationally.
REQ-014 In IDLE, o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we SHALL be 0.
REQ-015 o_ibus_ack SHALL be i_wb_ack & state==IBUS; o_dbus_ack SHALL be i_wb_ack & state==DBUS (no added latency).
REQ-016 o_ibus_rdt and o_dbus_rdt SHALL carry i_wb_rdt during their own ack cycle and be 0 otherwise.
REQ-017 i_wb_ack in IBUS or DBUS SHALL return the FSM to IDLE on the next edge; every grant is therefore followed by at least one IDLE cycle.
REQ-018 i_wb_ack arriving in IDLE SHALL be ignored: no requester ack, no state change.
REQ-019 If the granted requester deasserts cyc before ack, SHALL abort: o_wb_cyc drops the same cycle, FSM -> IDLE on the next edge, no ack issued.
REQ-020 The non-granted requester SHALL wait; its cyc is never dropped or acked by this block.
REQ-021 SHALL issue no ack for a transfer more than once.

Reset
REQ-022 On i_rst, immediately and independent of i_clk: state=IDLE, last_grant=1 (ibus wins first contention), timeout counter=0.
REQ-023 During and after reset, all outputs SHALL be 0 until a grant occurs.
REQ-024 Reset asserted mid-transfer SHALL drop o_wb_cyc at once and SHALL issue no ack.

Configuration
REQ-025 Macro SERV_BUS_SCHED_TIMEOUT_EN SHALL enable the watchdog.
REQ-026 With the macro: an 8-bit counter clears on each grant and increments each IBUS or DBUS cycle without i_wb_ack.
REQ-027 With the macro: when count == TIMEOUT_CYCLES and i_wb_ack=0, the granted requester's ack SHALL be asserted for that cycle with rdt=0, o_timeout SHALL pulse, and the FSM -> IDLE.
REQ-028 With the macro: if a real i_wb_ack coincides with the timeout cycle, the real ack SHALL win (rdt = i_wb_rdt) and o_timeout SHALL stay 0.
REQ-029 Without the macro: no counter, o_timeout tied to 0, transfers wait for i_wb_ack indefinitely; the port list is unchanged.

Verification
REQ-030 Reset, then i_ibus_cyc=1 at cycle 0, ack at cycle 3 with rdt=0x00000013 -> o_wb_cyc high cycles 1-3, o_ibus_ack and rdt=0x13 at cycle 3, IDLE at cycle 4.
REQ-031 Both cyc high after reset -> ibus granted first; after its ack and the IDLE cycle, dbus granted; a second contention grants ibus again.
REQ-032 DBUS write adr=0x100, dat=0xDEADBEEF, sel=0x3, we=1 -> o_wb_* match exactly; o_ibus_ack stays 0 throughout.
REQ-033 i_dbus_cyc dropped at cycle 2 of a grant -> o_wb_cyc=0 same cycle, no o_dbus_ack, IDLE next cycle; stray i_wb_ack in IDLE -> no ack.
REQ-034 With the macro and TIMEOUT_CYCLES=4, no ack -> o_dbus_ack and o_timeout at the 5th granted cycle with rdt=0; ack on that cycle -> o_timeout=0.
REQ-035 i_rst asserted mid-DBUS -> o_wb_cyc=0 immediately; after release, both cyc high -> ibus granted.

Source files
------------

// File: rtl/serv_bus_sched.sv
// Two-requester (ibus/dbus) round-robin scheduler in front of one Wishbone-style memory port.
// Define SERV_BUS_SCHED_TIMEOUT_EN to enable the watchdog that force-completes stalled transfers.
module serv_bus_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("serv_bus_sched: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StIbus, StDbus} state_e;

  state_e state_q;
  logic   last_grant_q;  // 0 = ibus, 1 = dbus
  logic   granted_cyc;
  logic   timeout;

  assign granted_cyc = ((state_q == StIbus) && i_ibus_cyc) || ((state_q == StDbus) && i_dbus_cyc);

`ifdef SERV_BUS_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q;

  // A real ack on the limit cycle takes precedence over the forced completion.
  assign timeout = granted_cyc && !i_wb_ack && (cnt_q == 8'(TIMEOUT_CYCLES));

  // Held at zero while idle so every grant starts counting from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 8'd0;
    end else if (state_q == StIdle) begin
      cnt_q <= 8'd0;
    end else if (!i_wb_ack) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_ibus_cyc && (!i_dbus_cyc || last_grant_q)) begin
            state_q      <= StIbus;
            last_grant_q <= 1'b0;
          end else if (i_dbus_cyc) begin
            state_q      <= StDbus;
            last_grant_q <= 1'b1;
          end
        end
        StIbus, StDbus: begin
          // Completion, abort (cyc dropped) or watchdog all return through idle.
          if (i_wb_ack || !granted_cyc || timeout) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_wb_cyc   = granted_cyc;
    o_wb_adr   = 32'd0;
    o_wb_dat   = 32'd0;
    o_wb_sel   = 4'd0;
    o_wb_we    = 1'b0;
    o_ibus_ack = 1'b0;
    o_ibus_rdt = 32'd0;
    o_dbus_ack = 1'b0;
    o_dbus_rdt = 32'd0;
    o_timeout  = timeout;
    unique case (state_q)
      StIbus: begin
        o_wb_adr   = i_ibus_adr;
        o_wb_sel   = 4'b1111;
        o_ibus_ack = i_wb_ack || timeout;
        o_ibus_rdt = i_wb_ack ? i_wb_rdt : 32'd0;
      end
      StDbus: begin
        o_wb_adr   = i_dbus_adr;
        o_wb_dat   = i_dbus_dat;
        o_wb_sel   = i_dbus_sel;
        o_wb_we    = i_dbus_we;
        o_dbus_ack = i_wb_ack || timeout;
        o_dbus_rdt = i_wb_ack ? i_wb_rdt : 32'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed self-checking bench for serv_bus_sched; inputs change 1 time unit after the rising edge.
module tb_serv_bus_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat, wb_rdt;
  logic [3:0]  dbus_sel;
  logic        ibus_cyc, dbus_cyc, dbus_we, wb_ack;
  logic [31:0] ibus_rdt, dbus_rdt, wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        ibus_ack, dbus_ack, wb_we, wb_cyc, timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serv_bus_sched #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ibus_adr = 32'h0000_0080; dbus_adr = 32'h0000_0200; dbus_dat = 32'd0; dbus_sel = 4'h0;
    dbus_we = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b0; wb_rdt = 32'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    ibus_cyc = 1'b1; dbus_cyc = 1'b1; wb_ack = 1'b1; wb_rdt = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if ({wb_cyc, ibus_ack, dbus_ack, wb_we, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {wb_cyc, ibus_ack, dbus_ack, wb_we, timeout});
    end
    checks++;
    if ({wb_adr, wb_dat, wb_sel, ibus_rdt, dbus_rdt} !== '0) begin
      errors++; $display("FAIL reset_data: adr=%h dat=%h sel=%h irdt=%h drdt=%h want all 0",
                         wb_adr, wb_dat, wb_sel, ibus_rdt, dbus_rdt);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_ibus_fetch;
    do_reset();
    ibus_cyc = 1'b1;
    #1;
    checks++;
    if (wb_cyc !== 1'b0) begin errors++; $display("FAIL fetch_c0_idle: got %b want 0", wb_cyc); end
    tick();  // cycle 1
    checks++;
    if ({wb_cyc, wb_adr, wb_sel, wb_we, wb_dat} !== {1'b1, 32'h80, 4'hF, 1'b0, 32'd0}) begin
      errors++; $display("FAIL fetch_c1: cyc=%b adr=%h sel=%h we=%b dat=%h want 1 80 f 0 0",
                         wb_cyc, wb_adr, wb_sel, wb_we, wb_dat);
    end
    tick();  // cycle 2
    checks++;
    if ({wb_cyc, ibus_ack} !== 2'b10) begin
      errors++; $display("FAIL fetch_c2: cyc,ack=%b want 10", {wb_cyc, ibus_ack});
    end
    tick();  // cycle 3
    wb_ack = 1'b1; wb_rdt = 32'h0000_0013;
    #1;
    checks++;
    if ({wb_cyc, ibus_ack, ibus_rdt, dbus_ack} !== {1'b1, 1'b1, 32'h13, 1'b0}) begin
      errors++; $display("FAIL fetch_c3_ack: cyc=%b ack=%b rdt=%h dack=%b want 1 1 13 0",
                         wb_cyc, ibus_ack, ibus_rdt, dbus_ack);
    end
    tick();  // cycle 4: ack removed, cyc still high, must be idle
    wb_ack = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, ibus_ack, ibus_rdt} !== 34'd0) begin
      errors++; $display("FAIL fetch_c4_idle: cyc=%b ack=%b rdt=%h want 0 0 0", wb_cyc, ibus_ack, ibus_rdt);
    end
    clear_inputs();
  endtask

  task automatic test_arbitration;
    do_reset();
    ibus_cyc = 1'b1; dbus_cyc = 1'b1;
    tick();  // first contention -> ibus
    wb_ack = 1'b1; wb_rdt = 32'h11;
    #1;
    checks++;
    if ({wb_cyc, wb_adr, ibus_ack, ibus_rdt, dbus_ack} !== {1'b1, 32'h80, 1'b1, 32'h11, 1'b0}) begin
      errors++; $display("FAIL arb_first_ibus: cyc=%b adr=%h iack=%b irdt=%h dack=%b want 1 80 1 11 0",
                         wb_cyc, wb_adr, ibus_ack, ibus_rdt, dbus_ack);
    end
    tick();
    wb_ack = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0) begin errors++; $display("FAIL arb_gap_idle: cyc=%b want 0", wb_cyc); end
    tick();  // second grant -> dbus
    wb_ack = 1'b1; wb_rdt = 32'h22;
    #1;
    checks++;
    if ({wb_adr, dbus_ack, dbus_rdt, ibus_ack, ibus_rdt} !== {32'h200, 1'b1, 32'h22, 1'b0, 32'd0}) begin
      errors++; $display("FAIL arb_then_dbus: adr=%h dack=%b drdt=%h iack=%b irdt=%h want 200 1 22 0 0",
                         wb_adr, dbus_ack, dbus_rdt, ibus_ack, ibus_rdt);
    end
    tick();
    wb_ack = 1'b0;
    tick();  // third contention -> ibus again
    #1;
    checks++;
    if ({wb_cyc, wb_adr} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL arb_ibus_again: cyc=%b adr=%h want 1 80", wb_cyc, wb_adr);
    end
    wb_ack = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_dbus_write;
    do_reset();
    dbus_cyc = 1'b1; dbus_adr = 32'h100; dbus_dat = 32'hDEAD_BEEF; dbus_sel = 4'h3; dbus_we = 1'b1;
    tick();
    checks++;
    if ({wb_cyc, wb_adr, wb_dat, wb_sel, wb_we, ibus_ack} !==
        {1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL dwrite_bus: cyc=%b adr=%h dat=%h sel=%h we=%b iack=%b want 1 100 deadbeef 3 1 0",
                         wb_cyc, wb_adr, wb_dat, wb_sel, wb_we, ibus_ack);
    end
    tick();
    wb_ack = 1'b1; wb_rdt = 32'h5A5A_5A5A;
    #1;
    checks++;
    if ({dbus_ack, dbus_rdt, ibus_ack} !== {1'b1, 32'h5A5A_5A5A, 1'b0}) begin
      errors++; $display("FAIL dwrite_ack: dack=%b drdt=%h iack=%b want 1 5a5a5a5a 0",
                         dbus_ack, dbus_rdt, ibus_ack);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_abort;
    do_reset();
    dbus_cyc = 1'b1;
    tick();  // cycle 1
    tick();  // cycle 2: requester gives up
    dbus_cyc = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, dbus_ack} !== 2'b00) begin
      errors++; $display("FAIL abort_drop: cyc,dack=%b want 00", {wb_cyc, dbus_ack});
    end
    tick();  // cycle 3: idle, stray ack with cyc back high
    dbus_cyc = 1'b1; wb_ack = 1'b1; wb_rdt = 32'h77;
    #1;
    checks++;
    if ({wb_cyc, dbus_ack, ibus_ack, dbus_rdt} !== 35'd0) begin
      errors++; $display("FAIL abort_stray_ack: cyc=%b dack=%b iack=%b drdt=%h want 0 0 0 0",
                         wb_cyc, dbus_ack, ibus_ack, dbus_rdt);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    dbus_cyc = 1'b1; wb_rdt = 32'h55;
`ifdef SERV_BUS_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({wb_cyc, dbus_ack, timeout} !== 3'b100) begin
        errors++; $display("FAIL tmo_wait%0d: cyc,dack,tmo=%b want 100", i, {wb_cyc, dbus_ack, timeout});
      end
    end
    tick();  // 5th granted cycle
    checks++;
    if ({dbus_ack, timeout, dbus_rdt} !== {1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL tmo_fire: dack=%b tmo=%b drdt=%h want 1 1 0", dbus_ack, timeout, dbus_rdt);
    end
    tick();
    checks++;
    if ({wb_cyc, timeout} !== 2'b00) begin
      errors++; $display("FAIL tmo_idle: cyc,tmo=%b want 00", {wb_cyc, timeout});
    end
    for (int i = 1; i <= 5; i++) tick();  // regranted, now on its 5th cycle
    wb_ack = 1'b1; wb_rdt = 32'h66;
    #1;
    checks++;
    if ({dbus_ack, timeout, dbus_rdt} !== {1'b1, 1'b0, 32'h66}) begin
      errors++; $display("FAIL tmo_real_ack_wins: dack=%b tmo=%b drdt=%h want 1 0 66",
                         dbus_ack, timeout, dbus_rdt);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({wb_cyc, dbus_ack, timeout} !== 3'b100) begin
        errors++; $display("FAIL notmo_wait%0d: cyc,dack,tmo=%b want 100", i, {wb_cyc, dbus_ack, timeout});
      end
    end
    wb_ack = 1'b1;
    #1;
    checks++;
    if ({dbus_ack, dbus_rdt} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL notmo_ack: dack=%b drdt=%h want 1 55", dbus_ack, dbus_rdt);
    end
`endif
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    dbus_cyc = 1'b1;
    tick();
    checks++;
    if (wb_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_granted: cyc=%b want 1", wb_cyc); end
    rst = 1'b1; wb_ack = 1'b1;
    #1;
    checks++;
    if ({wb_cyc, dbus_ack, ibus_ack} !== 3'b000) begin
      errors++; $display("FAIL rstmid_drop: cyc,dack,iack=%b want 000", {wb_cyc, dbus_ack, ibus_ack});
    end
    tick();
    rst = 1'b0; wb_ack = 1'b0; ibus_cyc = 1'b1;
    tick();
    checks++;
    if ({wb_cyc, wb_adr, wb_we} !== {1'b1, 32'h80, 1'b0}) begin
      errors++; $display("FAIL rstmid_ibus_first: cyc=%b adr=%h we=%b want 1 80 0", wb_cyc, wb_adr, wb_we);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ibus_fetch();
    test_arbitration();
    test_dbus_write();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
